// File: rtl/adder_feeder.sv
// adder_feeder: serial nibble loader for the 16-input pipelined adder tree.
// Collects 16 operands, launches them, waits out latency, returns the sum.
module adder_feeder #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_data,
  output logic        in_ready,
  output logic [63:0] nib_o,
  input  logic [7:0]  sum_i,
  output logic        res_valid,
  output logic [7:0]  res_data,
  input  logic        res_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    COLLECT,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_wait;
  logic [63:0] r_nib;
  logic [7:0]  r_res;
  logic        r_res_valid;
  logic        w_accept;

  assign in_ready  = (r_state == COLLECT);
  assign busy      = ~in_ready;
  assign w_accept  = in_valid & in_ready;
  assign nib_o     = r_nib;
  assign res_data  = r_res;
  assign res_valid = r_res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_nib       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_nib[{r_cnt, 2'b00} +: 4] <= in_data;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_wait  <= 4'(LATENCY);
          r_state <= WAIT;
        end
        WAIT: begin
          r_wait <= r_wait - 4'd1;
          // sum_i is valid in the cycle the counter shows 1
          if (r_wait == 4'd1) begin
            r_res       <= sum_i;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_feeder.sv
// tb_adder_feeder: randomized scoreboard bench for adder_feeder,
// with a pipelined adder-tree model driving sum_i.
module tb_adder_feeder;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        res_ready = 1'b0;
  logic        in_ready;
  logic        res_valid;
  logic        busy;
  logic [63:0] nib_o;
  logic [7:0]  sum_i;
  logic [7:0]  res_data;

  int total = 0;
  int bad = 0;
  int ecnt = 0;

  typedef struct {
    logic [7:0] sum;
    int         due;
  } res_t;

  res_t        rq[$];
  logic [63:0] lq[$];
  int          rise_edges[$];
  logic [63:0] last_bus = '0;

  logic [7:0] pipe[LAT];

  always #5 clk = ~clk;

  adder_feeder #(.LATENCY(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .nib_o(nib_o),
    .sum_i(sum_i),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready),
    .busy(busy)
  );

  function automatic logic [7:0] bus_sum(input logic [63:0] b);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(b[4*k +: 4]);
    return 8'(s);
  endfunction

  // adder tree: samples nib_o each edge, sum appears LAT edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= bus_sum(nib_o);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sum_i = pipe[LAT-1];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // monitor / scoreboard
  logic prev_ir = 1'b1;
  logic prev_rv = 1'b0;
  logic prev_hs = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ir <= 1'b1;
      prev_rv <= 1'b0;
      prev_hs <= 1'b0;
    end else begin
      if (prev_hs) begin
        chk("in_ready_after_hs", in_ready, 1);
        chk("res_valid_after_hs", res_valid, 0);
      end
      if (prev_ir && !in_ready) begin
        if (lq.size() == 0) begin
          chk("launch_unexpected", 1, 0);
        end else begin
          last_bus <= lq[0];
          chk("launch_bus", nib_o, lq.pop_front());
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) begin
          chk("res_unexpected", res_valid, 0);
        end else begin
          chk("res_data", res_data, rq[0].sum);
          chk("in_ready_in_done", in_ready, 0);
          chk("busy_in_done", busy, 1);
          chk("nib_hold", nib_o, last_bus);
          if (!prev_rv) begin
            chk("res_edge", ecnt, rq[0].due);
            rise_edges.push_back(ecnt);
          end
          if (res_ready) void'(rq.pop_front());
        end
      end
      prev_ir <= in_ready;
      prev_rv <= res_valid;
      prev_hs <= res_valid & res_ready;
    end
  end

  task automatic send_group(input logic [3:0] v[16], input int maxgap);
    int s = 0;
    logic [63:0] bus = '0;
    res_t e;
    for (int k = 0; k < 16; k++) begin
      bus[4*k +: 4] = v[k];
      s += int'(v[k]);
    end
    lq.push_back(bus);
    for (int k = 0; k < 16; k++) begin
      int g;
      int n;
      logic acc;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v[k];
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    e.sum = 8'(s);
    e.due = ecnt + LAT + 1;
    rq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (rq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", rq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g[16];
    int n;
    int base;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_nib", nib_o, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // 1: all 0xF back-to-back
    res_ready = 1'b1;
    for (int k = 0; k < 16; k++) g[k] = 4'hF;
    send_group(g, 0);
    drain();

    // 2: 0..F with random gaps
    for (int k = 0; k < 16; k++) g[k] = 4'(k);
    send_group(g, 3);
    drain();

    // 3: all 0x1, consumer stalls 10 cycles
    res_ready = 1'b0;
    for (int k = 0; k < 16; k++) g[k] = 4'h1;
    send_group(g, 0);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_res_valid", res_valid, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("stall_in_ready", in_ready, 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_single_hs", res_valid, 0);
    chk("stall_queue", rq.size(), 0);

    // 4: 0x3 group, then 0xA held valid while busy
    for (int k = 0; k < 16; k++) g[k] = 4'h3;
    send_group(g, 0);
    in_valid = 1'b1;
    in_data  = 4'hA;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_wait_ready", in_ready, 1);
    for (int k = 0; k < 16; k++) g[k] = 4'($urandom_range(15, 0));
    send_group(g, 0);
    drain();

    // 5: reset during WAIT
    for (int k = 0; k < 16; k++) g[k] = 4'h7;
    send_group(g, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    rq.delete();
    #1;
    chk("mid_rst_nib", nib_o, 0);
    chk("mid_rst_res", res_data, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_valid", res_valid, 0);
    rst_n = 1'b1;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
    end
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    for (int k = 0; k < 16; k++) g[k] = 4'h2;
    send_group(g, 0);
    drain();

    // 6: three back-to-back groups, period check
    base = rise_edges.size();
    for (int k = 0; k < 16; k++) g[k] = 4'h0;
    send_group(g, 0);
    for (int k = 0; k < 16; k++) g[k] = 4'hF;
    send_group(g, 0);
    for (int k = 0; k < 16; k++) g[k] = (k % 8 < 3) ? 4'hF : 4'h0;
    send_group(g, 0);
    drain();
    chk("period_count", rise_edges.size() - base, 3);
    if (rise_edges.size() == base + 3) begin
      for (int i = base; i < base + 2; i++)
        chk("period", rise_edges[i+1] - rise_edges[i], 16 + LAT + 2);
    end

    // random groups with random gaps
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) g[k] = 4'($urandom_range(15, 0));
      send_group(g, 2);
    end
    drain();
    chk("launch_queue", lq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_feeder.md
Name: adder_feeder

Overview:
Front-end loader for the 16-input, 5-stage pipelined nibble adder tree.
- Accepts a serial stream of 4-bit operands over a valid/ready handshake.
- Assembles 16 operands into a parallel bus that drives the adder tree's operand inputs.
- Waits out the adder pipeline latency, captures the 8-bit sum, and returns it over a second valid/ready handshake.
- Sits between a byte/nibble-stream source and the adder tree. Same clk/rst_n domain as the adder.

Parameters:
LATENCY, 5, clock edges from adder operand sampling to its sum output being valid; legal 1..15.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operand nibble valid.
in_data  input  4  operand nibble.
in_ready  output  1  feeder can accept a nibble.
nib_o  output  64  operand bus to adder; slot k = nib_o[4k+3:4k], k=0 drives operand a ... k=15 drives operand p.
sum_i  input  8  sum output of adder tree.
res_valid  output  1  result valid.
res_data  output  8  captured 16-operand sum.
res_ready  input  1  consumer accepts result.
busy  output  1  high whenever state is not COLLECT.

Behaviour:
Reset, asynchronous, rst_n=0:
- state=COLLECT, slot counter cnt=0, wait counter=0.
- nib_o=0, res_data=0, res_valid=0, busy=0.
- in_ready=1 once rst_n=1.

States: COLLECT, LAUNCH, WAIT, DONE.
- in_ready = (state==COLLECT), combinational from state.
- busy = !in_ready.
- in_valid is ignored when in_ready=0.

COLLECT:
- Each accept (in_valid & in_ready) writes in_data into slot cnt at the clock edge, then cnt increments.
- Other slots hold their values.
- Gaps in in_valid are allowed; cnt holds during gaps.
- Accept with cnt==15 (cycle T): writes slot 15, cnt wraps to 0, next state LAUNCH.

LAUNCH (cycle T+1, the launch cycle L):
- nib_o holds the complete group; the adder samples it at the end of L.
- Wait counter loaded with LATENCY; next state WAIT.

WAIT:
- Wait counter decrements once per cycle.
- In the cycle where the counter reaches 1 (cycle L+LATENCY), sum_i is registered into res_data at the end of that cycle, and the next state is DONE.
- nib_o stays constant from L through DONE; it only changes on the next accept.

DONE:
- res_valid=1 from cycle T+2+LATENCY (T+7 at default).
- res_data is stable while res_valid=1.
- On res_valid & res_ready: res_valid=0 and state=COLLECT in the next cycle; in_ready rises that cycle.
- With res_ready held high, the group period is 16+LATENCY+2 cycles (23 at default).

Arithmetic:
- The feeder performs no addition; res_data = sum_i sampled as-is.
- Expected value is the sum of the 16 nibbles, maximum 240, which fits in 8 bits with no overflow.

Boundary conditions:
- Partial group (<16 nibbles) is never launched; it waits indefinitely for more input.
- rst_n asserted mid-COLLECT/WAIT/DONE: the group is discarded, all registers return to reset values, and no res_valid is produced. The adder shares rst_n, so no stale pipeline sum is captured.
- Slots are not cleared between groups; every slot is overwritten by the next group.
- res_ready held low: the block stays in DONE indefinitely, and in_ready stays 0.

Test Plan:
1. Reset, then stream 16 nibbles 0xF back-to-back, res_ready=1 -> res_valid rises exactly 7 cycles after the 16th accept, res_data=0xF0, in_ready=1 the following cycle.
2. Stream nibbles 0x0..0xF in order with random 0-3 cycle in_valid gaps -> nib_o=0xFEDCBA9876543210 in the launch cycle, res_data=0x78.
3. Group of all 0x1, res_ready=0 for 10 cycles after res_valid, then 1 -> res_data=0x10 stable throughout, in_ready=0 throughout, single handshake, then COLLECT.
4. Drive in_valid=1 continuously with data 0xA during LAUNCH/WAIT/DONE after a group of 0x3 -> those nibbles are not accepted, res_data=0x30, the next group starts with the first nibble after in_ready rises.
5. Assert rst_n=0 for 2 cycles during WAIT (3 cycles after launch) -> no res_valid, nib_o=0, res_data=0; a subsequent group of all 0x2 gives res_data=0x20.
6. Three consecutive groups (sums 0x00, 0xF0, 0x5A-compatible mix) with res_ready=1 -> results in order, res_valid pulses spaced 23 cycles apart.
